// File: rtl/mm_feed_pkg.sv
// Shared FSM state type and sizing helpers for the matrix-multiply tile feeder.
package mm_feed_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mmf_state_e;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int mmf_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Address width of an operand memory holding (dim/n) lane-groups of k words each.
    function automatic int mmf_addr_w(input int dim, input int n, input int k);
        return mmf_cnt_w((dim / n) * k);
    endfunction

    function automatic int mmf_tiles(input int mr, input int mc, input int n);
        return (mr / n) * (mc / n);
    endfunction

endpackage

// File: rtl/mmf_delay_line.sv
// Fixed-depth shift register with synchronous clear; DEPTH=0 degenerates to a wire.
module mmf_delay_line #(
    parameter int W     = 8,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign dout_o = din_i;
        end else begin : g_pipe
            logic [W-1:0] stage_q [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= din_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign dout_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/mm_tile_feeder.sv
// Streams A/B operand tiles into an N x N systolic array with lane skew and PE init pulses.
// Define MMF_PERF_CNT_EN to add the perf_cycles busy-cycle counter output.
module mm_tile_feeder
    import mm_feed_pkg::*;
#(
    parameter  int D_W  = 8,
    parameter  int N    = 4,
    parameter  int MR   = 8,
    parameter  int MC   = 8,
    parameter  int K    = 8,
    localparam int AW_A = mmf_addr_w(MR, N, K),
    localparam int AW_B = mmf_addr_w(MC, N, K),
    localparam int T    = mmf_tiles(MR, MC, N),
    localparam int TW   = mmf_cnt_w(T + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stall,
    output logic               busy,
    output logic               done,
    output logic               rd_en_A,
    output logic [AW_A-1:0]    rd_addr_A,
    input  logic [N*D_W-1:0]   rd_data_A,
    output logic               rd_en_B,
    output logic [AW_B-1:0]    rd_addr_B,
    input  logic [N*D_W-1:0]   rd_data_B,
    output logic [N*D_W-1:0]   A_skew,
    output logic [N*D_W-1:0]   B_skew,
    output logic [N*N-1:0]     init_pe,
    output logic [TW-1:0]      tile_idx
`ifdef MMF_PERF_CNT_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    localparam int RT = MR / N;
    localparam int CT = MC / N;
    localparam int KW = mmf_cnt_w(K);
    localparam int RW = mmf_cnt_w(RT);
    localparam int CW = mmf_cnt_w(CT);
    localparam int DW = mmf_cnt_w(2 * N);

    mmf_state_e     state_q;
    logic [KW-1:0]  k_q;
    logic [RW-1:0]  r_q;
    logic [CW-1:0]  c_q;
    logic [DW-1:0]  drain_q;
    logic           req_q;
    logic           done_q;
    logic           issue;
    logic           first_d;
    logic           first_q;
    logic           ret_valid_d;
    logic           ret_valid_q;
    logic [N*D_W-1:0] a_lane_in;
    logic [N*D_W-1:0] b_lane_in;

    // req_q marks that (r,k)/(c,k) hold a read waiting to go out; it is loaded in the
    // first FEED cycle so the address is stable before the first rd_en.
    assign issue       = req_q && (state_q == FEED) && !stall && !rst;
    assign first_d     = issue && (k_q == '0);
    assign ret_valid_d = issue;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
            drain_q <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= FEED;
                        k_q     <= '0;
                        r_q     <= '0;
                        c_q     <= '0;
                        req_q   <= 1'b0;
                    end
                end
                FEED: begin
                    if (!req_q) begin
                        req_q <= 1'b1;
                    end else if (!stall) begin
                        if (k_q == KW'(K - 1)) begin
                            k_q <= '0;
                            if (c_q == CW'(CT - 1)) begin
                                c_q <= '0;
                                if (r_q == RW'(RT - 1)) begin
                                    r_q     <= '0;
                                    req_q   <= 1'b0;
                                    drain_q <= '0;
                                    state_q <= DRAIN;
                                end else begin
                                    r_q <= r_q + 1'b1;
                                end
                            end else begin
                                c_q <= c_q + 1'b1;
                            end
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_q == DW'(2 * N - 1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q     <= 1'b0;
            ret_valid_q <= 1'b0;
        end else begin
            first_q     <= first_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign rd_en_A   = issue;
    assign rd_en_B   = issue;
    assign rd_addr_A = AW_A'(int'(r_q) * K + int'(k_q));
    assign rd_addr_B = AW_B'(int'(c_q) * K + int'(k_q));
    assign tile_idx  = TW'(int'(r_q) * CT + int'(c_q));

    // Only a genuine read return enters the array; bubbles and idle cycles feed zeros.
    assign a_lane_in = ret_valid_q ? rd_data_A : '0;
    assign b_lane_in = ret_valid_q ? rd_data_B : '0;

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_skew
            mmf_delay_line #(.W(D_W), .DEPTH(gi)) u_skew_a (
                .clk    (clk),
                .rst    (rst),
                .din_i  (a_lane_in[gi*D_W +: D_W]),
                .dout_o (A_skew[gi*D_W +: D_W])
            );
            mmf_delay_line #(.W(D_W), .DEPTH(gi)) u_skew_b (
                .clk    (clk),
                .rst    (rst),
                .din_i  (b_lane_in[gi*D_W +: D_W]),
                .dout_o (B_skew[gi*D_W +: D_W])
            );
        end

        // first_q already carries one cycle of latency, so PE[x][y] needs x+y more.
        for (gi = 0; gi < N; gi++) begin : g_init_row
            for (gj = 0; gj < N; gj++) begin : g_init_col
                mmf_delay_line #(.W(1), .DEPTH(gi + gj)) u_init (
                    .clk    (clk),
                    .rst    (rst),
                    .din_i  (first_q),
                    .dout_o (init_pe[gi*N + gj])
                );
            end
        end
    endgenerate

`ifdef MMF_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if (state_q == IDLE && start) begin
            perf_q <= '0;
        end else if (busy && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mm_tile_feeder.sv
// Directed bench for mm_tile_feeder at N=2, MR=MC=K=4 (perf counter checked when MMF_PERF_CNT_EN is set).
module tb_mm_tile_feeder;

    localparam int D_W = 8;
    localparam int N   = 2;
    localparam int MR  = 4;
    localparam int MC  = 4;
    localparam int K   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stall = 1'b0;
    logic        busy, done;
    logic        rd_en_A, rd_en_B;
    logic [2:0]  rd_addr_A, rd_addr_B;
    logic [15:0] rd_data_A = 16'h0000;
    logic [15:0] rd_data_B = 16'h0000;
    logic [15:0] A_skew, B_skew;
    logic [3:0]  init_pe;
    logic [2:0]  tile_idx;
`ifdef MMF_PERF_CNT_EN
    logic [31:0] perf_cycles;
`endif

    logic [15:0] mem_a [8];
    logic [15:0] mem_b [8];

    int exp_a [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};
    int exp_b [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3, 4, 5, 6, 7};

    int n_checks = 0;
    int n_pass   = 0;

    mm_tile_feeder #(.D_W(D_W), .N(N), .MR(MR), .MC(MC), .K(K)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .rd_en_A   (rd_en_A),
        .rd_addr_A (rd_addr_A),
        .rd_data_A (rd_data_A),
        .rd_en_B   (rd_en_B),
        .rd_addr_B (rd_addr_B),
        .rd_data_B (rd_data_B),
        .A_skew    (A_skew),
        .B_skew    (B_skew),
        .init_pe   (init_pe),
        .tile_idx  (tile_idx)
`ifdef MMF_PERF_CNT_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    // Advance one cycle and answer the read issued in the cycle just ended (1-cycle latency);
    // non-read cycles return garbage so zero substitution is visible.
    task automatic tick();
        logic       ea, eb;
        logic [2:0] aa, ab;
        ea = rd_en_A;
        eb = rd_en_B;
        aa = rd_addr_A;
        ab = rd_addr_B;
        @(posedge clk);
        #1;
        rd_data_A = ea ? mem_a[aa] : 16'hDEAD;
        rd_data_B = eb ? mem_b[ab] : 16'hBEEF;
    endtask

    // Leaves the bench at +1 of cycle 0, the first cycle after start is accepted.
    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done got=%b exp=0", done); else n_pass++;
        n_checks++; if ({rd_en_A, rd_en_B} !== 2'b00) $display("FAIL rst_rd_en got=%b%b exp=00", rd_en_A, rd_en_B); else n_pass++;
        n_checks++; if ({rd_addr_A, rd_addr_B} !== 6'd0) $display("FAIL rst_addr got=%0d/%0d exp=0/0", rd_addr_A, rd_addr_B); else n_pass++;
        n_checks++; if ({A_skew, B_skew} !== 32'd0) $display("FAIL rst_skew got=%h/%h exp=0/0", A_skew, B_skew); else n_pass++;
        n_checks++; if (init_pe !== 4'd0) $display("FAIL rst_init_pe got=%b exp=0000", init_pe); else n_pass++;
        n_checks++; if (tile_idx !== 3'd0) $display("FAIL rst_tile_idx got=%0d exp=0", tile_idx); else n_pass++;
        tick();
        #2;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_over_start busy got=%b exp=0", busy); else n_pass++;
        $display("reset: outputs idle after rst, start during rst ignored");
    endtask

    task automatic test_sequence();
        logic       exp_en;
        logic [7:0] e0a, e1a, e0b, e1b;
        int         done_cyc;
        int         n_rd;
        done_cyc = -1;
        n_rd     = 0;
        do_start();
        for (int cyc = 0; cyc < 25; cyc++) begin
            start = (cyc == 8 || cyc == 9);
            #2;
            exp_en = (cyc >= 1 && cyc <= 16);
            n_checks++; if (busy !== (cyc <= 21)) $display("FAIL seq_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc <= 21)); else n_pass++;
            n_checks++; if (done !== (cyc == 21)) $display("FAIL seq_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 21)); else n_pass++;
            n_checks++; if (rd_en_A !== exp_en || rd_en_B !== exp_en) $display("FAIL seq_rd_en cyc=%0d got=%b%b exp=%b", cyc, rd_en_A, rd_en_B, exp_en); else n_pass++;
            if (exp_en) begin
                n_rd++;
                n_checks++; if (rd_addr_A !== 3'(exp_a[cyc-1])) $display("FAIL seq_addr_a cyc=%0d got=%0d exp=%0d", cyc, rd_addr_A, exp_a[cyc-1]); else n_pass++;
                n_checks++; if (rd_addr_B !== 3'(exp_b[cyc-1])) $display("FAIL seq_addr_b cyc=%0d got=%0d exp=%0d", cyc, rd_addr_B, exp_b[cyc-1]); else n_pass++;
                n_checks++; if (tile_idx !== 3'((cyc - 1) / 4)) $display("FAIL seq_tile_idx cyc=%0d got=%0d exp=%0d", cyc, tile_idx, (cyc - 1) / 4); else n_pass++;
            end
            e0a = 8'h00; e0b = 8'h00; e1a = 8'h00; e1b = 8'h00;
            if (cyc >= 2 && cyc <= 17) begin
                e0a = mem_a[exp_a[cyc-2]][7:0];
                e0b = mem_b[exp_b[cyc-2]][7:0];
            end
            if (cyc >= 3 && cyc <= 18) begin
                e1a = mem_a[exp_a[cyc-3]][15:8];
                e1b = mem_b[exp_b[cyc-3]][15:8];
            end
            n_checks++; if (A_skew !== {e1a, e0a}) $display("FAIL seq_a_skew cyc=%0d got=%h exp=%h", cyc, A_skew, {e1a, e0a}); else n_pass++;
            n_checks++; if (B_skew !== {e1b, e0b}) $display("FAIL seq_b_skew cyc=%0d got=%h exp=%h", cyc, B_skew, {e1b, e0b}); else n_pass++;
            if (done && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        start = 1'b0;
        $display("sequence: reads=%0d done_cycle=%0d", n_rd, done_cyc);
    endtask

    task automatic test_skew();
        int done_cyc;
        done_cyc = -1;
        do_start();
        for (int cyc = 0; cyc < 25; cyc++) begin
            #2;
            if (cyc == 2) begin
                n_checks++; if (A_skew[7:0] !== 8'h11) $display("FAIL skew_lane0 cyc=%0d got=%h exp=11", cyc, A_skew[7:0]); else n_pass++;
                n_checks++; if (A_skew[15:8] !== 8'h00) $display("FAIL skew_lane1_early cyc=%0d got=%h exp=00", cyc, A_skew[15:8]); else n_pass++;
            end
            if (cyc == 3) begin
                n_checks++; if (A_skew[15:8] !== 8'h22) $display("FAIL skew_lane1 cyc=%0d got=%h exp=22", cyc, A_skew[15:8]); else n_pass++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        n_checks++; if (done_cyc != 21) $display("FAIL skew_done_cycle got=%0d exp=21", done_cyc); else n_pass++;
        $display("skew: word 2211 split across lanes, done_cycle=%0d", done_cyc);
    endtask

    task automatic test_stall();
        logic exp_en;
        int   idx;
        int   done_cyc;
        done_cyc = -1;
        do_start();
        for (int cyc = 0; cyc < 28; cyc++) begin
            stall = (cyc >= 7 && cyc <= 9);
            #2;
            exp_en = (cyc >= 1 && cyc <= 6) || (cyc >= 10 && cyc <= 19);
            idx    = (cyc <= 6) ? cyc - 1 : cyc - 4;
            n_checks++; if (rd_en_A !== exp_en || rd_en_B !== exp_en) $display("FAIL stall_rd_en cyc=%0d got=%b%b exp=%b", cyc, rd_en_A, rd_en_B, exp_en); else n_pass++;
            n_checks++; if (done !== (cyc == 24)) $display("FAIL stall_done cyc=%0d got=%b exp=%b", cyc, done, (cyc == 24)); else n_pass++;
            n_checks++; if (busy !== (cyc <= 24)) $display("FAIL stall_busy cyc=%0d got=%b exp=%b", cyc, busy, (cyc <= 24)); else n_pass++;
            if (exp_en) begin
                n_checks++; if (rd_addr_A !== 3'(exp_a[idx]) || rd_addr_B !== 3'(exp_b[idx])) $display("FAIL stall_addr cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, rd_addr_A, rd_addr_B, exp_a[idx], exp_b[idx]); else n_pass++;
            end
            if (cyc >= 7 && cyc <= 9) begin
                n_checks++; if (rd_addr_A !== 3'd2 || rd_addr_B !== 3'd6) $display("FAIL stall_addr_hold cyc=%0d got=%0d/%0d exp=2/6", cyc, rd_addr_A, rd_addr_B); else n_pass++;
                n_checks++; if (tile_idx !== 3'd1) $display("FAIL stall_tile_hold cyc=%0d got=%0d exp=1", cyc, tile_idx); else n_pass++;
            end
            if (cyc >= 8 && cyc <= 10) begin
                n_checks++; if (A_skew[7:0] !== 8'h00 || B_skew[7:0] !== 8'h00) $display("FAIL stall_lane0_zero cyc=%0d got=%h/%h exp=00/00", cyc, A_skew[7:0], B_skew[7:0]); else n_pass++;
            end
            if (cyc == 11) begin
                n_checks++; if (A_skew[7:0] !== 8'h12 || B_skew[7:0] !== 8'h46) $display("FAIL stall_resume_data cyc=%0d got=%h/%h exp=12/46", cyc, A_skew[7:0], B_skew[7:0]); else n_pass++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        stall = 1'b0;
        $display("stall: 3-cycle bubble at tile 1 k=2, done_cycle=%0d", done_cyc);
    endtask

    task automatic test_init_pe();
        logic [3:0] exp_init;
        int         s;
        int         pulses;
        pulses = 0;
        do_start();
        for (int cyc = 0; cyc < 25; cyc++) begin
            #2;
            exp_init = 4'b0000;
            for (int x = 0; x < 2; x++) begin
                for (int y = 0; y < 2; y++) begin
                    s = cyc - x - y - 1;
                    if (s == 1 || s == 5 || s == 9 || s == 13) exp_init[x*2 + y] = 1'b1;
                end
            end
            n_checks++; if (init_pe !== exp_init) $display("FAIL init_pe cyc=%0d got=%b exp=%b", cyc, init_pe, exp_init); else n_pass++;
            if (init_pe[3] === 1'b1) pulses++;
            tick();
        end
        n_checks++; if (pulses != 4) $display("FAIL init_pe11_pulses got=%0d exp=4", pulses); else n_pass++;
        $display("init_pe: PE[1][1] pulses=%0d", pulses);
    endtask

    task automatic test_reset_mid();
        int done_cyc;
        done_cyc = -1;
        do_start();
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL mid_rst_busy got=%b/%b exp=0/0", busy, done); else n_pass++;
        n_checks++; if ({rd_en_A, rd_en_B} !== 2'b00) $display("FAIL mid_rst_rd_en got=%b%b exp=00", rd_en_A, rd_en_B); else n_pass++;
        n_checks++; if ({rd_addr_A, rd_addr_B, tile_idx} !== 9'd0) $display("FAIL mid_rst_addr got=%0d/%0d/%0d exp=0/0/0", rd_addr_A, rd_addr_B, tile_idx); else n_pass++;
        n_checks++; if ({A_skew, B_skew} !== 32'd0 || init_pe !== 4'd0) $display("FAIL mid_rst_pipes got=%h/%h/%b exp=0/0/0", A_skew, B_skew, init_pe); else n_pass++;
        do_start();
        for (int cyc = 0; cyc < 25; cyc++) begin
            #2;
            if (cyc == 1) begin
                n_checks++; if (rd_en_A !== 1'b1 || rd_addr_A !== 3'd0 || rd_addr_B !== 3'd0 || tile_idx !== 3'd0) $display("FAIL mid_rst_restart got=%b %0d/%0d t%0d exp=1 0/0 t0", rd_en_A, rd_addr_A, rd_addr_B, tile_idx); else n_pass++;
            end
            if (done && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        n_checks++; if (done_cyc != 21) $display("FAIL mid_rst_done_cycle got=%0d exp=21", done_cyc); else n_pass++;
        $display("reset_mid: aborted at cycle 6, rerun done_cycle=%0d", done_cyc);
    endtask

`ifdef MMF_PERF_CNT_EN
    task automatic test_perf();
        do_start();
        for (int cyc = 0; cyc < 27; cyc++) begin
            #2;
            if (cyc == 0) begin
                n_checks++; if (perf_cycles !== 32'd0) $display("FAIL perf_clear got=%0d exp=0", perf_cycles); else n_pass++;
            end
            if (cyc == 22 || cyc == 26) begin
                n_checks++; if (perf_cycles !== 32'd22) $display("FAIL perf_total cyc=%0d got=%0d exp=22", cyc, perf_cycles); else n_pass++;
            end
            tick();
        end
        $display("perf: busy cycles=%0d", perf_cycles);
    endtask
`endif

    initial begin
        for (int a = 0; a < 8; a++) begin
            mem_a[a] = {8'(8'h20 + a), 8'(8'h10 + a)};
            mem_b[a] = {8'(8'h60 + a), 8'(8'h40 + a)};
        end
        mem_a[0] = 16'h2211;

        test_reset();
        test_sequence();
        test_skew();
        test_stall();
        test_init_pe();
        test_reset_mid();
`ifdef MMF_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mm_tile_feeder.md
MM_TILE_FEEDER -- requirements
Module: mm_tile_feeder

Interface
REQ-001 SHALL have parameter D_W, default 8, operand width.
REQ-002 SHALL have parameter N, default 4, systolic array edge size.
REQ-003 SHALL have parameters MR, MC, K, default 8 each, for C[MR x MC] = A[MR x K] * B[K x MC]; MR and MC are multiples of N; K >= 1.
REQ-004 SHALL have ports: clk in 1, clock; rst in 1, reset (synchronous, active-high).
REQ-005 SHALL have ports: start in 1, run request; stall in 1, bubble request; busy out 1; done out 1, one-cycle pulse.
REQ-006 SHALL have ports: rd_en_A out 1; rd_addr_A out AW_A=$clog2((MR/N)*K); rd_data_A in N*D_W.
REQ-007 SHALL have ports: rd_en_B out 1; rd_addr_B out AW_B=$clog2((MC/N)*K); rd_data_B in N*D_W.
REQ-008 SHALL have ports: A_skew out N*D_W and B_skew out N*D_W, lane x in bits [(x+1)*D_W-1 : x*D_W].
REQ-009 SHALL have ports: init_pe out N*N, bit x*N+y for PE[x][y]; tile_idx out $clog2(T+1), where T=(MR/N)*(MC/N).

Function
REQ-010 SHALL use FSM states IDLE, FEED, DRAIN, DONE.
REQ-011 SHALL transition IDLE->FEED on start; start SHALL be ignored outside IDLE.
REQ-012 SHALL visit tiles (r,c) row-major: c fastest, r in 0..MR/N-1, c in 0..MC/N-1; tile_idx = r*(MC/N)+c.
REQ-013 SHALL, in FEED with stall=0, each cycle assert rd_en_A and rd_en_B with rd_addr_A=r*K+k and rd_addr_B=c*K+k, then advance k; tile advances after k=K-1 with no bubble.
REQ-014 SHALL, in FEED with stall=1, deassert both rd_en and hold k, r, c, and both addresses.
REQ-015 SHALL treat memory read latency as exactly 1 cycle: rd_data is valid the cycle after rd_en.
REQ-016 SHALL drive lane x of A_skew and B_skew with lane x of rd_data delayed x further cycles; lane 0 is undelayed.
REQ-017 SHALL substitute zero for a lane input in any cycle whose rd_data is not the return of an issued read (stall bubble, DRAIN, IDLE).
REQ-018 SHALL keep skew pipelines shifting every cycle regardless of stall.
REQ-019 SHALL assert init_pe[x][y] for exactly one cycle, x+y+1 cycles after the k=0 read issue of each tile.
REQ-020 SHALL move FEED->DRAIN after the read with k=K-1 of tile T-1.
REQ-021 SHALL hold DRAIN for 2N cycles, then enter DONE for one cycle with done=1, then return to IDLE.
REQ-022 SHALL assert busy in FEED, DRAIN and DONE.

Reset
REQ-023 SHALL, on rst (also mid-operation), enter IDLE, clear k/r/c and all skew and init pipelines, and drive busy, done, rd_en_*, rd_addr_*, A_skew, B_skew, init_pe and tile_idx to 0.
REQ-024 SHALL apply rst with priority over start and stall in the same cycle.

Configuration
REQ-025 SHALL, with MMF_PERF_CNT_EN defined, add output perf_cycles, 32 bits, cleared on start acceptance, incrementing each busy cycle, saturating at 32'hFFFFFFFF, held after done, and reset to 0.
REQ-026 SHALL, without MMF_PERF_CNT_EN, omit port perf_cycles and its logic.

Structure
REQ-027 SHALL place the FSM state enum and address-width/tile-count constant functions in package mm_feed_pkg.
REQ-028 SHALL implement each per-lane delay as sub-module mmf_delay_line (params W, DEPTH; DEPTH=0 is a wire), used for skew lanes and init_pe.

Verification
REQ-029 SHALL verify: N=2, MR=MC=K=4, start, no stall -> rd_addr_A = 0-3, 0-3, 4-7, 4-7; rd_addr_B = 0-3, 4-7, 0-3, 4-7 over 16 cycles; done 2N+1=5 cycles after the last read.
REQ-030 SHALL verify: rd_data_A={8'h22,8'h11} returned at cycle t -> A_skew lane0=8'h11 at t, lane1=8'h22 at t+1.
REQ-031 SHALL verify: stall high 3 cycles at k=2 of tile 1 -> rd_en low 3 cycles, addresses held, zeros in lane 0, done 3 cycles later than REQ-029.
REQ-032 SHALL verify: init_pe[1][1] (N=2) pulses 3 cycles after each tile's k=0 read, 4 pulses total.
REQ-033 SHALL verify: rst in FEED -> next cycle busy=0 and outputs 0; new start reruns from tile 0.
REQ-034 SHALL verify: with MMF_PERF_CNT_EN defined -> perf_cycles=22 at done for the REQ-029 case.
